// File: rtl/nem_ohmux_sel_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nem_ohmux_sel_ctrl_if
// Description : Request handshake and relay-select bundle for the one-hot
//               NEM relay mux select controller.
// Revision    : 1.0
// ============================================================================
interface nem_ohmux_sel_ctrl_if;
    logic       REQ_VLD;
    logic       REQ_RDY;
    logic       REQ_EN;
    logic [1:0] REQ_SEL;
    logic       S0;
    logic       S1;
    logic       S2;
    logic       S3;
    logic       SETTLED;
    logic       ERR;

    modport master (
        output REQ_VLD, REQ_EN, REQ_SEL,
        input  REQ_RDY, S0, S1, S2, S3, SETTLED, ERR
    );

    modport slave (
        input  REQ_VLD, REQ_EN, REQ_SEL,
        output REQ_RDY, S0, S1, S2, S3, SETTLED, ERR
    );
endinterface
`default_nettype wire

// File: rtl/nem_ohmux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nem_ohmux_sel_ctrl
// Description : Break-before-make select sequencer for a 4-input one-hot NEM
//               relay mux, with relay pull-out/pull-in wait timing.
// Revision    : 1.0
// ============================================================================
module nem_ohmux_sel_ctrl #(
    parameter int T_OFF = 4,
    parameter int T_ON  = 6
) (
    input  wire logic            CP,
    input  wire logic            RST,
    nem_ohmux_sel_ctrl_if.slave  bus
);

    localparam int c_T_MAX = (T_OFF > T_ON) ? T_OFF : T_ON;
    localparam int c_CNT_W = $clog2(c_T_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_OFF_LD = c_CNT_W'(T_OFF - 1);
    localparam logic [c_CNT_W-1:0] c_ON_LD  = c_CNT_W'(T_ON - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]           r_sel;
    logic [3:0]           w_sel_nxt;
    logic [1:0]           r_tgt_idx;
    logic [1:0]           w_tgt_idx_nxt;
    logic                 r_tgt_en;
    logic                 w_tgt_en_nxt;
    logic                 r_err;
    logic                 r_prev_pend;
    logic                 r_prev_en;
    logic [1:0]           r_prev_sel;
    logic                 w_rdy;
    logic                 w_accept;
    logic                 w_err_set;
    logic [3:0]           w_req_onehot;

    assign w_rdy        = (r_state == ST_IDLE);
    assign w_accept     = w_rdy && bus.REQ_VLD;
    assign w_req_onehot = 4'b0001 << bus.REQ_SEL;

    // A held-but-unaccepted request must stay stable until it is taken.
    assign w_err_set = r_prev_pend &&
                       (!bus.REQ_VLD || (bus.REQ_EN != r_prev_en) || (bus.REQ_SEL != r_prev_sel));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_sel_nxt     = r_sel;
        w_tgt_idx_nxt = r_tgt_idx;
        w_tgt_en_nxt  = r_tgt_en;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (bus.REQ_EN) begin
                        if (r_sel == 4'b0000) begin
                            w_state_nxt = ST_MAKE;
                            w_cnt_nxt   = c_ON_LD;
                            w_sel_nxt   = w_req_onehot;
                        end else if (r_sel != w_req_onehot) begin
                            w_state_nxt   = ST_BREAK;
                            w_cnt_nxt     = c_OFF_LD;
                            w_sel_nxt     = 4'b0000;
                            w_tgt_idx_nxt = bus.REQ_SEL;
                            w_tgt_en_nxt  = 1'b1;
                        end
                    end else if (r_sel != 4'b0000) begin
                        w_state_nxt  = ST_BREAK;
                        w_cnt_nxt    = c_OFF_LD;
                        w_sel_nxt    = 4'b0000;
                        w_tgt_en_nxt = 1'b0;
                    end
                end
            end
            ST_BREAK: begin
                if (r_cnt == '0) begin
                    if (r_tgt_en) begin
                        w_state_nxt = ST_MAKE;
                        w_cnt_nxt   = c_ON_LD;
                        w_sel_nxt   = 4'b0001 << r_tgt_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_MAKE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sel       <= 4'b0000;
            r_tgt_idx   <= 2'd0;
            r_tgt_en    <= 1'b0;
            r_err       <= 1'b0;
            r_prev_pend <= 1'b0;
            r_prev_en   <= 1'b0;
            r_prev_sel  <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel       <= w_sel_nxt;
            r_tgt_idx   <= w_tgt_idx_nxt;
            r_tgt_en    <= w_tgt_en_nxt;
            r_prev_pend <= bus.REQ_VLD && !w_rdy;
            r_prev_en   <= bus.REQ_EN;
            r_prev_sel  <= bus.REQ_SEL;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.REQ_RDY = w_rdy;
    assign bus.SETTLED = w_rdy;
    assign bus.ERR     = r_err;
    assign bus.S0      = r_sel[0];
    assign bus.S1      = r_sel[1];
    assign bus.S2      = r_sel[2];
    assign bus.S3      = r_sel[3];

endmodule
`default_nettype wire

// File: tb/tb_nem_ohmux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nem_ohmux_sel_ctrl
// Description : Directed vector bench for the NEM relay mux select sequencer.
// Revision    : 1.0
// ============================================================================
module tb_nem_ohmux_sel_ctrl;

    typedef struct {
        logic       rst;
        logic       vld;
        logic       en;
        logic [1:0] sel;
        logic [3:0] s;
        logic       settled;
        logic       rdy;
        logic       err;
    } vec_t;

    logic CP;
    logic RST;
    int   checks;
    int   failures;
    vec_t vecs[$];

    nem_ohmux_sel_ctrl_if bus();

    nem_ohmux_sel_ctrl #(
        .T_OFF (4),
        .T_ON  (6)
    ) dut (
        .CP  (CP),
        .RST (RST),
        .bus (bus)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    function automatic void add(input logic rst, input logic vld, input logic en,
                                input logic [1:0] sel, input logic [3:0] s,
                                input logic settled, input logic rdy, input logic err,
                                input int n);
        vec_t v;
        v.rst = rst; v.vld = vld; v.en = en; v.sel = sel;
        v.s = s; v.settled = settled; v.rdy = rdy; v.err = err;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic step(input logic rst, input logic vld, input logic en, input logic [1:0] sel);
        @(negedge CP);
        RST         = rst;
        bus.REQ_VLD = vld;
        bus.REQ_EN  = en;
        bus.REQ_SEL = sel;
        @(posedge CP);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] s, input logic settled,
                       input logic rdy, input logic err);
        logic [6:0] act;
        logic [6:0] exp;
        logic [3:0] s_act;
        s_act = {bus.S3, bus.S2, bus.S1, bus.S0};
        act   = {s_act, bus.SETTLED, bus.REQ_RDY, bus.ERR};
        exp   = {s, settled, rdy, err};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got S=%b SETTLED=%b RDY=%b ERR=%b, expected S=%b SETTLED=%b RDY=%b ERR=%b",
                     name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
        checks++;
        if ($countones(s_act) > 1) begin
            failures++;
            $display("FAIL %s_onehot: got S=%b, expected at most one select high", name, s_act);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        RST         = 1'b1;
        bus.REQ_VLD = 1'b0;
        bus.REQ_EN  = 1'b0;
        bus.REQ_SEL = 2'd0;

        //   rst vld en sel   S        set rdy err  n
        add(1, 0, 0, 2'd0, 4'b0000, 1, 1, 0, 1);   // reset state
        add(0, 1, 1, 2'd2, 4'b0100, 0, 0, 0, 1);   // connect 2 from empty: no break
        add(0, 0, 0, 2'd0, 4'b0100, 0, 0, 0, 5);
        add(0, 0, 0, 2'd0, 4'b0100, 1, 1, 0, 1);   // settled 6 after accept
        add(0, 1, 1, 2'd0, 4'b0000, 0, 0, 0, 1);   // switch 2 -> 0: break
        add(0, 0, 0, 2'd0, 4'b0000, 0, 0, 0, 3);
        add(0, 0, 0, 2'd0, 4'b0001, 0, 0, 0, 6);   // make
        add(0, 0, 0, 2'd0, 4'b0001, 1, 1, 0, 1);   // settled 10 after accept
        add(0, 1, 1, 2'd1, 4'b0000, 0, 0, 0, 1);   // switch 0 -> 1
        add(0, 0, 1, 2'd3, 4'b0000, 0, 0, 0, 3);   // input change after accept is harmless
        add(0, 0, 0, 2'd0, 4'b0010, 0, 0, 0, 6);
        add(0, 0, 0, 2'd0, 4'b0010, 1, 1, 0, 1);
        add(0, 1, 0, 2'd2, 4'b0000, 0, 0, 0, 1);   // disconnect from 1
        add(0, 0, 0, 2'd0, 4'b0000, 0, 0, 0, 3);
        add(0, 0, 0, 2'd0, 4'b0000, 1, 1, 0, 2);   // back idle, no make
        add(0, 1, 0, 2'd1, 4'b0000, 1, 1, 0, 1);   // disconnect while empty
        add(0, 1, 1, 2'd3, 4'b1000, 0, 0, 0, 1);   // connect 3 from empty
        add(0, 0, 0, 2'd0, 4'b1000, 0, 0, 0, 5);
        add(0, 0, 0, 2'd0, 4'b1000, 1, 1, 0, 1);
        add(0, 1, 1, 2'd3, 4'b1000, 1, 1, 0, 2);   // reconnect same index
        add(0, 0, 0, 2'd0, 4'b1000, 1, 1, 0, 1);
        add(1, 1, 1, 2'd0, 4'b0000, 1, 1, 0, 1);   // reset wins over request
        add(0, 0, 0, 2'd0, 4'b0000, 1, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].en, vecs[i].sel);
            chk($sformatf("vec%0d", i), vecs[i].s, vecs[i].settled, vecs[i].rdy, vecs[i].err);
        end

        // Reset asserted on the third cycle of MAKE aborts cleanly.
        step(0, 1, 1, 2'd1); chk("abort_m1", 4'b0010, 0, 0, 0);
        step(0, 0, 0, 2'd0); chk("abort_m2", 4'b0010, 0, 0, 0);
        step(1, 0, 0, 2'd0); chk("abort_rst", 4'b0000, 1, 1, 0);
        step(0, 0, 0, 2'd0); chk("abort_after", 4'b0000, 1, 1, 0);

        // Changing REQ_SEL while stalled sets sticky ERR; captured index still wins.
        step(0, 1, 1, 2'd1); chk("err_acc", 4'b0010, 0, 0, 0);
        step(0, 1, 1, 2'd1); chk("err_hold", 4'b0010, 0, 0, 0);
        step(0, 1, 1, 2'd2); chk("err_set", 4'b0010, 0, 0, 1);
        step(0, 1, 1, 2'd2); chk("err_m4", 4'b0010, 0, 0, 1);
        step(0, 1, 1, 2'd2); chk("err_m5", 4'b0010, 0, 0, 1);
        step(0, 0, 0, 2'd0); chk("err_m6", 4'b0010, 0, 0, 1);
        step(0, 0, 0, 2'd0); chk("err_done", 4'b0010, 1, 1, 1);
        step(0, 0, 0, 2'd0); chk("err_sticky", 4'b0010, 1, 1, 1);
        step(1, 0, 0, 2'd0); chk("err_clr", 4'b0000, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
